// File: rtl/rsa_mont_exp.sv
// rtl/rsa_mont_exp.sv - modular exponentiation x^e mod n using bit-serial Montgomery multiplication
//
// Ports:
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   i_start    : request pulse, sampled only while idle
//   i_number   : base x (WIDTH bits)
//   i_key      : exponent e (EXP_WIDTH bits)
//   i_n        : modulus n (WIDTH bits), must be odd and >= 3, with x < n
//   i_abort    : cancel the running operation (ignored while idle)
//   o_result   : x^e mod n, held until the next completion (0 after a rejected request)
//   o_finished : one-cycle completion pulse
//   o_error    : one-cycle pulse alongside o_finished for a rejected request
//   o_busy     : registered, high whenever the controller is not idle
//
// Exponent bits are consumed LSB first. t holds the running square in Montgomery
// form (base * 2^WIDTH mod n) while m stays in the plain domain: Mont(m, t)
// = m * t / 2^WIDTH, so multiplying a plain value by a Montgomery-form value
// yields a plain product and no final conversion step is needed.
module rsa_mont_exp #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_number,
    input  logic [EXP_WIDTH-1:0] i_key,
    input  logic [WIDTH-1:0]     i_n,
    input  logic                 i_abort,
    output logic [WIDTH-1:0]     o_result,
    output logic                 o_finished,
    output logic                 o_error,
    output logic                 o_busy
);

    // Accumulators carry two guard bits: with A < 2n and b < n, A + b + n < 4n < 2^(WIDTH+2).
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(EXP_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_LOAD,
        S_MONT,
        S_CORR,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic [WIDTH-1:0]     n_r;
    logic [EXP_WIDTH-1:0] key_sh;
    logic [WIDTH-1:0]     t;
    logic [WIDTH-1:0]     m;
    logic [WIDTH-1:0]     op1;
    logic [WIDTH-1:0]     op2;
    logic [AW-1:0]        a1;
    logic [AW-1:0]        a2;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bidx;

    logic                 req_bad;
    logic                 cnt_last;
    logic                 bit_last;
    logic                 unit1_active;
    logic [AW-1:0]        n_ext;
    logic [WIDTH:0]       t_dbl;
    logic [WIDTH-1:0]     t_prep;
    logic [WIDTH-1:0]     m_corr;
    logic [WIDTH-1:0]     t_corr;

    // One bit-serial Montgomery step: add a[j]*b, make even by adding n, halve.
    function automatic logic [AW-1:0] mont_step(
        input logic [AW-1:0]    acc,
        input logic             abit,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] nn
    );
        logic [AW-1:0] s;
        s = acc + (abit ? {2'b00, b} : {AW{1'b0}});
        if (s[0]) begin
            s = s + {2'b00, nn};
        end
        return s >> 1;
    endfunction

    assign req_bad      = ~i_n[0] | (i_n < WIDTH'(3)) | (i_number >= i_n);
    assign cnt_last     = (cnt == CW'(WIDTH - 1));
    assign bit_last     = (bidx == BW'(EXP_WIDTH - 1));
    assign unit1_active = key_sh[0];
    assign n_ext        = {2'b00, n_r};

    // Doubling step used to bring x into the Montgomery domain; t < n so 2t < 2n.
    assign t_dbl  = {t, 1'b0};
    assign t_prep = WIDTH'((t_dbl >= {1'b0, n_r}) ? (t_dbl - {1'b0, n_r}) : t_dbl);

    // Final conditional subtraction; accumulators are < 2n after MONT.
    assign m_corr = WIDTH'((a1 >= n_ext) ? (a1 - n_ext) : a1);
    assign t_corr = WIDTH'((a2 >= n_ext) ? (a2 - n_ext) : a2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nx = req_bad ? S_ERR : S_PREP;
                end
            end
            S_PREP: begin
                if (cnt_last) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: state_nx = S_MONT;
            S_MONT: begin
                if (cnt_last) begin
                    state_nx = S_CORR;
                end
            end
            S_CORR: state_nx = bit_last ? S_DONE : S_LOAD;
            S_DONE: state_nx = S_IDLE;
            S_ERR:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (state != S_IDLE && i_abort) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_r        <= '0;
            key_sh     <= '0;
            t          <= '0;
            m          <= '0;
            op1        <= '0;
            op2        <= '0;
            a1         <= '0;
            a2         <= '0;
            cnt        <= '0;
            bidx       <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
            o_error    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            o_error    <= 1'b0;
            o_busy     <= (state_nx != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        n_r    <= i_n;
                        key_sh <= i_key;
                        t      <= i_number;
                        m      <= '0;
                        cnt    <= '0;
                        bidx   <= '0;
                    end
                end
                S_PREP: begin
                    t   <= t_prep;
                    cnt <= cnt + CW'(1);
                    if (cnt_last) begin
                        m <= WIDTH'(1);
                    end
                end
                S_LOAD: begin
                    a1  <= '0;
                    a2  <= '0;
                    op1 <= m;
                    op2 <= t;
                    cnt <= '0;
                end
                S_MONT: begin
                    if (unit1_active) begin
                        a1 <= mont_step(a1, op1[0], t, n_r);
                    end
                    a2  <= mont_step(a2, op2[0], t, n_r);
                    op1 <= op1 >> 1;
                    op2 <= op2 >> 1;
                    cnt <= cnt + CW'(1);
                end
                S_CORR: begin
                    if (unit1_active) begin
                        m <= m_corr;
                    end
                    t      <= t_corr;
                    bidx   <= bidx + BW'(1);
                    key_sh <= key_sh >> 1;
                end
                S_DONE: begin
                    if (!i_abort) begin
                        o_result   <= m;
                        o_finished <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (!i_abort) begin
                        o_result   <= '0;
                        o_finished <= 1'b1;
                        o_error    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
